fifo_burst_reader: RTL and testbench

//  Read-side consumer for the team's synchronous FIFO. On a start pulse, pops exactly burst_len words

---
 rtl/fifo_rd_pkg.sv | 20 ++
 rtl/fifo_rd_skid_buf.sv | 55 +++++
 rtl/fifo_burst_reader.sv | 148 ++++++++++++++
 tb/tb_fifo_burst_reader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the FIFO burst reader and its 3-entry output buffer.
package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int BUF_DEPTH = 3;
    localparam int OCC_W     = 2;
    localparam int PTR_W     = 2;

    // Circular pointer advance; wraps at BUF_DEPTH rather than at a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// 3-entry circular buffer that absorbs the FIFO's one-cycle read latency.
// Simultaneous write and read are allowed; occupancy is then unchanged.
module fifo_rd_skid_buf
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [OCC_W-1:0] occ
);

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             do_wr_s;
    logic             do_rd_s;

    assign do_rd_s = rd_en && (occ_q != OCC_W'(0));
    assign do_wr_s = wr_en && ((occ_q != OCC_W'(BUF_DEPTH)) || do_rd_s);

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_wr_s) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_rd_s) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_wr_s, do_rd_s})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign occ     = occ_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops burst_len words from a registered-read FIFO and replays them on a valid/ready stream.
// Optional empty-stall abort is enabled by defining FIFO_RD_TIMEOUT_EN.
module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    state_t           state_q;
    logic [LEN_W-1:0] remaining_q;
    logic             inflight_q;
    logic             done_q;
    logic [OCC_W-1:0] occ_s;
    logic [OCC_W:0]   window_s;
    logic             rd_en_s;
    logic             m_valid_s;

    // Words already committed (buffered or in flight) must leave room for the next pop.
    assign window_s  = {1'b0, occ_s} + {{OCC_W{1'b0}}, inflight_q};
    assign rd_en_s   = (state_q == RUN) && !fifo_empty && (window_s < (OCC_W+1)'(BUF_DEPTH));
    assign m_valid_s = (occ_s != OCC_W'(0));

    fifo_rd_skid_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (inflight_q),
        .wr_data (fifo_dout),
        .rd_en   (m_valid_s && m_ready),
        .rd_data (m_data),
        .occ     (occ_s)
    );

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q;
    logic               abort_q;
    logic               err_q;
    logic               timeout_hit_s;

    assign timeout_hit_s = (state_q == RUN) && fifo_empty && (stall_q == STALL_W'(TIMEOUT - 1));

    // Consecutive empty cycles while in RUN; any non-empty cycle restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state_q == RUN) && fifo_empty) begin
            stall_q <= stall_q + STALL_W'(1);
        end else begin
            stall_q <= '0;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Burst sequencing: accept start, count issued pops, wait for the buffer to drain, pulse done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            done_q      <= 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
            abort_q     <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else begin
            inflight_q <= rd_en_s;
            done_q     <= 1'b0;
`ifdef FIFO_RD_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (burst_len == LEN_W'(0)) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            remaining_q <= burst_len;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (rd_en_s) begin
                        remaining_q <= remaining_q - LEN_W'(1);
                        if (remaining_q == LEN_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
`ifdef FIFO_RD_TIMEOUT_EN
                    else if (timeout_hit_s) begin
                        state_q     <= DRAIN;
                        remaining_q <= '0;
                        abort_q     <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (!inflight_q && (occ_s == OCC_W'(0))) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
`ifdef FIFO_RD_TIMEOUT_EN
                        err_q   <= abort_q;
`endif
                    end
                end
                DONE: begin
                    state_q <= IDLE;
`ifdef FIFO_RD_TIMEOUT_EN
                    abort_q <= 1'b0;
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign fifo_rd_en = rd_en_s;
    assign m_valid    = m_valid_s;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench: table of bursts run against a queue-based FIFO and stream model.
module tb_fifo_burst_reader;

    localparam int WIDTH = 8;
    localparam int LEN_W = 8;
`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TMO     = 4;
    localparam int LATE_AT = 6;
`else
    localparam int TMO     = 255;
    localparam int LATE_AT = 10;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] burst_len;
    logic             busy;
    logic             done;
    logic             err;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;

    always #5 clk = ~clk;

    fifo_burst_reader #(
        .WIDTH   (WIDTH),
        .LEN_W   (LEN_W),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .burst_len  (burst_len),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data)
    );

    typedef struct {
        int len;
        int prefill;
        int late_words;
        int late_at;
        int ready_mode;   // 0 always ready, 1 toggling, 2 random
        int restart_at;   // cycle of an extra start pulse while busy, -1 none
        int base;         // first data word, -1 random
        int exp_words;
        int exp_err;
        int exp_done;     // cycle of done pulse, -1 unchecked
        int exp_first;    // cycle of first m_valid, -1 never, -2 unchecked
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic [WIDTH-1:0] exp_q[$];
    int               pushed;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(int len, int prefill, int late_words, int late_at, int ready_mode,
                                int restart_at, int base, int exp_words, int exp_err,
                                int exp_done, int exp_first);
        vec_t v;
        v.len = len; v.prefill = prefill; v.late_words = late_words; v.late_at = late_at;
        v.ready_mode = ready_mode; v.restart_at = restart_at; v.base = base;
        v.exp_words = exp_words; v.exp_err = exp_err; v.exp_done = exp_done; v.exp_first = exp_first;
        return v;
    endfunction

    function automatic logic rdy(int mode, int cyc);
        case (mode)
            0:       return 1'b1;
            1:       return (cyc % 2) == 0;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    // Words entering the FIFO; the first len of them are what the stream must carry.
    task automatic push_word(input int base, input int len);
        logic [WIDTH-1:0] w;
        w = (base >= 0) ? WIDTH'(base + pushed) : WIDTH'($urandom);
        fifo_q.push_back(w);
        if (pushed < len) exp_q.push_back(w);
        pushed++;
    endtask

    task automatic run_burst(input vec_t v);
        int   pops, delivered, done_cyc, first_valid, err_cnt, done_cnt;
        logic pop_pending, prev_hold;
        logic [WIDTH-1:0] prev_data;
        pops = 0; delivered = 0; done_cyc = -10; first_valid = -1; err_cnt = 0; done_cnt = 0;
        fifo_q.delete(); exp_q.delete(); pushed = 0;
        @(negedge clk);
        for (int i = 0; i < v.prefill; i++) push_word(v.base, v.len);
        start = 1'b1; burst_len = LEN_W'(v.len);
        fifo_empty = (fifo_q.size() == 0);
        m_ready = rdy(v.ready_mode, 0);
        #1;
        check("idle_before_start", busy, 0);
        pop_pending = fifo_rd_en;
        prev_hold = 1'b0; prev_data = '0;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            start = (cyc == v.restart_at);
            if (start) burst_len = LEN_W'(3);
            if (pop_pending && fifo_q.size() > 0) begin
                fifo_dout = fifo_q.pop_front();
                pops++;
            end
            if (cyc == v.late_at) for (int i = 0; i < v.late_words; i++) push_word(v.base, v.len);
            fifo_empty = (fifo_q.size() == 0);
            m_ready = rdy(v.ready_mode, cyc);
            #1;
            if (cyc == done_cyc + 1) begin
                check("done_single_cycle", done, 0);
                check("idle_after_done", busy, 0);
                break;
            end
            check("busy", busy, 1);
            if (fifo_rd_en) check("pop_while_empty", fifo_empty, 0);
            check("window_le_3", (pops + int'(fifo_rd_en) - delivered) <= 3, 1);
            if (prev_hold) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                check("no_extra_word", delivered < v.exp_words, 1);
                if (exp_q.size() > 0) check("data_order", m_data, exp_q.pop_front());
                delivered++;
            end
            if (err) begin
                err_cnt++;
                check("err_with_done", done, 1);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("delivered_at_done", delivered, v.exp_words);
            end
            prev_hold = m_valid && !m_ready;
            prev_data = m_data;
            pop_pending = fifo_rd_en;
        end
        check("done_count", done_cnt, 1);
        check("words", delivered, v.exp_words);
        check("pops", pops, v.exp_words);
        check("err_pulses", err_cnt, v.exp_err);
        if (v.exp_done >= 0) check("done_cycle", done_cyc, v.exp_done);
        if (v.exp_first >= -1) check("first_valid_cycle", first_valid, v.exp_first);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit   pend;
        int   len;
        int   pre;
        logic [WIDTH-1:0] w;

        rst = 1'b1; start = 1'b0; burst_len = '0; fifo_dout = '0; fifo_empty = 1'b1; m_ready = 1'b0;

        // len, pre, late, at, rdy, restart, base, words, err, done, first
        vecs.push_back(mk(5, 5, 0, -1, 0, -1, 'h11, 5, 0, 9, 3));
        vecs.push_back(mk(6, 3, 3, LATE_AT, 0, -1, 'h40, 6, 0, -1, 3));
        vecs.push_back(mk(8, 8, 0, -1, 1, -1, 'h80, 8, 0, -1, -2));
        vecs.push_back(mk(0, 3, 0, -1, 0, -1, 'h20, 0, 0, 1, -1));
        vecs.push_back(mk(10, 10, 0, -1, 0, 4, -1, 10, 0, 14, 3));
        vecs.push_back(mk(1, 1, 0, -1, 0, -1, 'hA5, 1, 0, 5, 3));
`ifdef FIFO_RD_TIMEOUT_EN
        vecs.push_back(mk(4, 1, 0, -1, 0, -1, 'h33, 1, 1, -1, 3));
`endif
        for (int i = 0; i < 6; i++) begin
            len = $urandom_range(1, 20);
`ifdef FIFO_RD_TIMEOUT_EN
            pre = len;
`else
            pre = $urandom_range(0, len);
`endif
            vecs.push_back(mk(len, pre, len - pre, $urandom_range(1, 15), 2, -1, -1, len, 0, -1, -2));
        end

        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_valid", m_valid, 0);
        check("rst_data", m_data, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_burst(vecs[i]);

        // Reset mid-burst with two words buffered and one in flight.
        @(negedge clk);
        start = 1'b1; burst_len = LEN_W'(6); fifo_empty = 1'b0; m_ready = 1'b0;
        #1 pend = fifo_rd_en;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (pend) begin
                w = WIDTH'(8'h60 + c);
                fifo_dout = w;
            end
            #1 pend = fifo_rd_en;
        end
        check("pre_rst_valid", m_valid, 1);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", m_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", fifo_rd_en, 0);
        @(negedge clk);
        check("post_rst_valid", m_valid, 0);
        check("post_rst_done", done, 0);
        rst = 1'b0;
        run_burst(mk(2, 2, 0, -1, 0, -1, 'h71, 2, 0, 6, 3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
